// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative multiply/divide unit, one bit per cycle.
// Multiply is radix-2 shift-add and divide is restoring shift-subtract.
// Both run on operand magnitudes, and a single FIX cycle applies the signs.
// The unit takes one request at a time through a valid/ready handshake.
// It holds the registered result until the consumer takes it.
module md_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             out_div_by_zero
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic             op_signed_q, op_signed_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  // The multiplicand for a multiply, or the divisor for a divide.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // For a multiply: the product high half, then the multiplier that shifts out.
  // For a divide: the low half holds the dividend, which shifts into the quotient.
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             div_zero;

  assign in_ready        = (state_q == S_IDLE);
  assign busy            = (state_q == S_CALC) || (state_q == S_FIX);
  assign out_valid       = (state_q == S_DONE);
  assign out_hi          = hi_q;
  assign out_lo          = lo_q;
  assign out_div_by_zero = dz_q;

  // Operand magnitudes, taken at acceptance.
  assign mag1 = (op_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign mag2 = (op_signed && src2[WIDTH-1]) ? -src2 : src2;

  // One shift-add step. The carry lands in the top bit of the shifted high half.
  assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};

  // One restoring step. A borrow out of the (WIDTH+1)-bit trial means the divisor does not fit.
  assign div_trial = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, opnd_q};

  // Sign correction used in the FIX cycle. Most-negative / -1 wraps naturally here.
  assign div_zero = (opnd_q == '0);
  assign prod_fix = (op_signed_q && (sign1_q ^ sign2_q)) ? -acc_q : acc_q;
  assign quo_fix  = div_zero ? '1 :
                    (op_signed_q && (sign1_q ^ sign2_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = (op_signed_q && sign1_q) ? -rem_q : rem_q;

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    // NOTE: every signal gets a default first, so a path that skips it cannot infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_div_d    = op_div_q;
    op_signed_d = op_signed_q;
    sign1_d     = sign1_q;
    sign2_d     = sign2_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dz_d        = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          state_d     = S_CALC;
          cnt_d       = CNT_W'(WIDTH);
          op_div_d    = op_div;
          op_signed_d = op_signed;
          sign1_d     = src1[WIDTH-1];
          sign2_d     = src2[WIDTH-1];
          rem_d       = '0;
          if (op_div) begin
            opnd_d = mag2;
            acc_d  = {{WIDTH{1'b0}}, mag1};
          end else begin
            opnd_d = mag1;
            acc_d  = {{WIDTH{1'b0}}, mag2};
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_div_q) begin
          if (!div_diff[WIDTH]) begin
            rem_d = div_diff[WIDTH-1:0];
            acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_trial[WIDTH-1:0];
            acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (op_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
          dz_d = div_zero;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
          dz_d = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides every other transition, including a request or a result handshake.
    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_div_q    <= 1'b0;
      op_signed_q <= 1'b0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_div_q    <= op_div_d;
      op_signed_q <= op_signed_d;
      sign1_q     <= sign1_d;
      sign2_q     <= sign2_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dz_q        <= dz_d;
    end
  end

endmodule

// File: tb/tb_md_iter_unit.sv
// Self-checking bench for md_iter_unit.
// A 32-bit instance runs randomized and directed operations against a scoreboard.
// An 8-bit instance covers the narrow-width case.
module tb_md_iter_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, in_valid, op_div, op_signed, out_ready;
  logic [31:0] src1, src2;
  logic        in_ready, busy, out_valid, out_dz;
  logic [31:0] out_hi, out_lo;

  logic        flush8, in_valid8, op_div8, op_signed8, out_ready8;
  logic [7:0]  src1_8, src2_8;
  logic        in_ready8, busy8, out_valid8, out_dz8;
  logic [7:0]  out_hi8, out_lo8;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  md_iter_unit #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op_div(op_div), .op_signed(op_signed), .src1(src1), .src2(src2), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_hi(out_hi), .out_lo(out_lo),
    .out_div_by_zero(out_dz)
  );

  md_iter_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .op_div(op_div8), .op_signed(op_signed8), .src1(src1_8), .src2(src2_8), .busy(busy8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_hi(out_hi8), .out_lo(out_lo8),
    .out_div_by_zero(out_dz8)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t    e;
    longint  sa, sb;
    logic [63:0] p;
    int      q, r;
    e.dz = 1'b0;
    if (!div) begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000;
        e.hi = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        e.lo = q;
        e.hi = r;
      end
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: compare each result as it is handed over.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected result: hi %h lo %h with empty scoreboard", out_hi, out_lo);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_hi", out_hi, e.hi);
        check("out_lo", out_lo, e.lo);
        check("out_div_by_zero", out_dz, e.dz);
      end
    end
  end

  // Wait until the unit accepts, with a bound. Called just after a rising edge.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready wait", in_ready, 1);
  endtask

  // Issue one operation and follow it to the handshake.
  // hold > 0 keeps out_ready low for that many cycles after out_valid rises.
  task automatic run_op(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    logic [31:0] hold_hi, hold_lo;
    wait_ready();
    out_ready = (hold == 0);
    op_div = div; op_signed = sgn; src1 = a; src2 = b; in_valid = 1'b1;
    sb_q.push_back(model(div, sgn, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble the request inputs; they must not affect the running operation.
    src1 = $urandom; src2 = $urandom; op_div = 1'($urandom); op_signed = 1'($urandom);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 33);
    if (hold > 0) begin
      hold_hi = out_hi;
      hold_lo = out_lo;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("bp out_hi stable", out_hi, hold_hi);
        check("bp out_lo stable", out_lo, hold_lo);
        check("bp in_ready low", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("in_ready after handshake", in_ready, 1);
    check("out_valid after handshake", out_valid, 0);
  endtask

  // Narrow instance: one directed operation with fixed expected values.
  task automatic run_op8(input bit div, input bit sgn, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_hi, input logic [7:0] exp_lo);
    int n = 0;
    op_div8 = div; op_signed8 = sgn; src1_8 = a; src2_8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8 latency", n, 9);
    check("w8 out_hi", out_hi8, exp_hi);
    check("w8 out_lo", out_lo8, exp_lo);
    check("w8 out_div_by_zero", out_dz8, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    logic [31:0] a, b;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op_div = 1'b0; op_signed = 1'b0;
    src1 = '0; src2 = '0; out_ready = 1'b1;
    flush8 = 1'b0; in_valid8 = 1'b0; op_div8 = 1'b0; op_signed8 = 1'b0;
    src1_8 = '0; src2_8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_hi", out_hi, 0);
    check("reset out_lo", out_lo, 0);
    check("reset out_div_by_zero", out_dz, 0);

    // Directed cases.
    run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1, 1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1, 0, 32'h1234_5678, 32'h0000_0000, 0);
    run_op(1, 1, 32'h8765_4321, 32'h0000_0000, 0);
    run_op(0, 1, 32'h8000_0000, 32'h8000_0000, 0);

    // Flush 10 cycles after acceptance.
    op_div = 1'b1; op_signed = 1'b0; src1 = 32'd1000; src2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy before flush", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", busy, 0);
    check("flush in_ready", in_ready, 1);
    check("flush out_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("out_valid after flush", seen, 0);

    // Flush in the same cycle as a request: the request is not accepted.
    op_div = 1'b0; src1 = 32'd9; src2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush+valid in_ready", in_ready, 1);
    check("flush+valid busy", busy, 0);

    run_op(0, 0, 32'd3, 32'd5, 0);

    // Flush while a result is held: it is dropped without a handshake.
    out_ready = 1'b0;
    op_div = 1'b0; op_signed = 1'b0; src1 = 32'd11; src2 = 32'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("held result valid", out_valid, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in DONE out_valid", out_valid, 0);
    check("flush in DONE in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Back-pressure.
    run_op(0, 1, 32'hDEAD_BEEF, 32'h1357_9BDF, 5);
    run_op(1, 1, 32'hFFFF_FC00, 32'h0000_0033, 3);

    // Randomized operations, biased towards the corner operands.
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = 32'h8000_0000;
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(1'($urandom), 1'($urandom), a, b, (k % 9 == 0) ? 2 : 0);
    end

    // Narrow width.
    run_op8(0, 1, 8'h80, 8'h80, 8'h40, 8'h00);
    run_op8(1, 0, 8'd200, 8'd7, 8'd4, 8'd28);
    run_op8(0, 1, 8'hF9, 8'h03, 8'hFF, 8'hEB);

    repeat (3) @(posedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
